// File: rtl/resp_sig_capture.sv
// Response signature capture: folds a counted run of benchmark response words into a 32-bit MISR
// and compares the result with a golden signature. Optional macro: RESP_SIG_CHG_COUNT_EN.
module resp_sig_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] pat_count,
  input  logic [31:0] golden_sig,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        resp_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] signature,
`ifdef RESP_SIG_CHG_COUNT_EN
  output logic        pass,
  output logic [15:0] chg_count
`else
  output logic        pass
`endif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [31:0] Seed = 32'hFFFF_FFFF;
  // Feedback taps of x^32 + x^22 + x^2 + x + 1 (x^32 term is the shifted-out bit).
  localparam logic [31:0] Taps = 32'h0040_0007;

  logic [1:0]  state_q, state_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic        xfer;
  logic        start_ok;
  logic [31:0] sig_next;

  assign xfer     = resp_valid && (state_q == StRun);
  assign start_ok = start && (state_q == StIdle);
  assign sig_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? Taps : 32'h0) ^ resp_data;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          sig_d  = Seed;
          pass_d = 1'b0;
          if (pat_count == 16'd0) begin
            // Empty run: the seed is the final signature, so judge it right away.
            state_d = StDone;
            pass_d  = (golden_sig == Seed);
          end else begin
            state_d = StRun;
            cnt_d   = pat_count;
          end
        end
      end
      StRun: begin
        if (resp_valid) begin
          sig_d = sig_next;
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            // Register the verdict with the last word so it appears together with done.
            state_d = StDone;
            pass_d  = (sig_next == golden_sig);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sig_q   <= Seed;
      cnt_q   <= 16'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign resp_ready = (state_q == StRun);
  assign busy       = (state_q == StRun) || (state_q == StDone);
  assign done       = (state_q == StDone);
  assign signature  = sig_q;
  assign pass       = pass_q;

`ifdef RESP_SIG_CHG_COUNT_EN
  logic [15:0] chg_q, chg_d;

  always_comb begin
    chg_d = chg_q;
    if (start_ok) begin
      chg_d = 16'd0;
    end else if (xfer && resp_data[0] && (chg_q != 16'hFFFF)) begin
      chg_d = chg_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q <= 16'd0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign chg_count = chg_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok ^ xfer;
`endif

endmodule
